calc_sequencer: RTL
===================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable synchronized samples required to change a debounced button level (>=2).
REQ-002 Parameter SCAN_DIV, default 100_000, is the number of clk cycles each anode stays active (>=1).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 btn_next  input  1  raw, asynchronous advance button; active-high.
REQ-006 btn_clear  input  1  raw, asynchronous clear button; active-high.
REQ-007 btn_base  input  1  raw, asynchronous number-base toggle button; active-high.
REQ-008 op_sel  input  1  operation select switch, 1=add, 0=subtract; quasi-static.
REQ-009 en1, en2, en3  output  1 each  one-hot stage enables: operand-1 entry, operand-2 entry, result display.
REQ-010 load1, load2  output  1 each  single-cycle strobes that capture operand 1 and operand 2.
REQ-011 clear_ops  output  1  single-cycle strobe that zeroes both operand registers.
REQ-012 op_latched  output  1  operation frozen for the result stage.
REQ-013 is_dec  output  1  display base, 1=decimal, 0=hex.
REQ-014 an  output  4  active-low one-hot digit anode select.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 The debounced level SHALL change on the edge where the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing sample restarts the count.
REQ-017 A debounced 0->1 transition SHALL produce exactly one internal pulse, registered one cycle later; a 1->0 transition produces no pulse; a held button produces one pulse only.
REQ-018 The FSM SHALL have states ENTER_A, ENTER_B, SHOW with en1/en2/en3 high respectively; exactly one enable is high at all times.
REQ-019 A next pulse SHALL advance ENTER_A->ENTER_B, ENTER_B->SHOW, SHOW->ENTER_A.
REQ-020 ENTER_A->ENTER_B SHALL assert load1 for the single cycle in which the state register updates; ENTER_B->SHOW SHALL assert load2 for that cycle and latch op_sel into op_latched on the same edge.
REQ-021 SHOW->ENTER_A SHALL assert no strobe; operands keep their values.
REQ-022 A clear pulse SHALL force ENTER_A from any state and assert clear_ops for one cycle; op_latched resets to 1.
REQ-023 A clear pulse coincident with a next pulse SHALL take priority: go to ENTER_A, assert clear_ops, and assert neither load1 nor load2.
REQ-024 A base pulse SHALL toggle is_dec; it is independent of the FSM and of clear.
REQ-025 op_latched SHALL change only on ENTER_B->SHOW or clear/reset; op_sel changes in SHOW do not affect it.
REQ-026 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, an rotates 1110->1101->1011->0111->1110.
REQ-027 Scanning SHALL be free-running, unaffected by FSM state, clear, or base pulses.
REQ-028 load1, load2 and clear_ops SHALL never be high in the same cycle.

Reset
REQ-029 While reset_n=0: state=ENTER_A (en1=1, en2=0, en3=0), load1=load2=clear_ops=0, op_latched=1, is_dec=1, an=1110, all counters 0, debounced levels and synchronizers 0.
REQ-030 Reset assertion mid-transition or mid-debounce SHALL abort it with no strobe emitted; after deassertion the first pulse still needs a full DEBOUNCE_CYCLES run.

Verification (DEBOUNCE_CYCLES=4, SCAN_DIV=3)
REQ-031 Reset then btn_next held high 20 cycles -> exactly one load1 pulse, en2=1 from the cycle after load1, no further change.
REQ-032 btn_next glitch high 3 cycles, low 1, high 3 -> no pulse, state stays ENTER_A.
REQ-033 Three separated next presses with op_sel=0 before the second -> load1, then load2 with op_latched=0 and en3=1; toggling op_sel to 1 in SHOW -> op_latched stays 0; fourth press -> en1=1, no strobe.
REQ-034 btn_next and btn_clear rising in the same cycle while in ENTER_B -> state ENTER_A, one clear_ops pulse, load2 never asserted.
REQ-035 Run 12 cycles after reset -> an = 1110,1101,1011,0111, each held 3 cycles, then 1110; btn_base press mid-sequence -> is_dec 1->0, scan sequence undisturbed.
REQ-036 Assert reset_n=0 asynchronously in SHOW with btn_next mid-debounce -> outputs immediately at reset values, no load strobe after release.

Source files
------------

// File: rtl/calc_sequencer.sv
// Three-stage calculator sequencer: debounced buttons drive an operand/result FSM,
// a number-base toggle and a free-running 4-digit anode scanner.
module calc_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned SCAN_DIV        = 100_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_next,
    input  logic       btn_clear,
    input  logic       btn_base,
    input  logic       op_sel,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       load1,
    output logic       load2,
    output logic       clear_ops,
    output logic       op_latched,
    output logic       is_dec,
    output logic [3:0] an
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [2:0] {
        ENTER_A = 3'b001,
        ENTER_B = 3'b010,
        SHOW    = 3'b100
    } state_t;

    // Bit 0 = next, bit 1 = clear, bit 2 = base
    logic [2:0]    raw, sync1, sync2, level, level_d, rise, pulse;
    logic [DW-1:0] db_cnt [3];
    logic [SW-1:0] scan_cnt;
    state_t        state, state_nx;

    assign raw  = {btn_base, btn_clear, btn_next};
    assign rise = level & ~level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_d <= '0;
            pulse   <= '0;
            for (int unsigned i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= rise;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != level[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        level[i]  <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    function automatic state_t advance(input state_t s, input logic nxt, input logic clr);
        if (clr) return ENTER_A;
        if (!nxt) return s;
        case (s)
            ENTER_A: return ENTER_B;
            ENTER_B: return SHOW;
            default: return ENTER_A;
        endcase
    endfunction

    assign state_nx = advance(state, pulse[0], pulse[1]);

    // Strobes are registered from the pre-pulse rise and the look-ahead state so they
    // are high exactly in the cycle whose closing edge performs the state change.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ENTER_A;
            load1      <= 1'b0;
            load2      <= 1'b0;
            clear_ops  <= 1'b0;
            op_latched <= 1'b1;
            is_dec     <= 1'b1;
        end else begin
            state     <= state_nx;
            load1     <= rise[0] & ~rise[1] & (state_nx == ENTER_A);
            load2     <= rise[0] & ~rise[1] & (state_nx == ENTER_B);
            clear_ops <= rise[1];
            if (pulse[1])
                op_latched <= 1'b1;
            else if (pulse[0] && state == ENTER_B)
                op_latched <= op_sel;
            if (pulse[2])
                is_dec <= ~is_dec;
        end
    end

    assign {en3, en2, en1} = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= '0;
            an       <= 4'b1110;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            an       <= {an[2:0], an[3]};
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

endmodule
